// File: rtl/apb4_req_master_pkg.sv
// Shared types and constants for the request-driven APB4 initiator.
// Response data is stored at the widest legal APB width and sliced by the master.
package apb4_req_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb4_mst_state_e;

   localparam logic [2:0] PPROT_PRIV   = 3'b001;
   localparam logic [2:0] PPROT_NONSEC = 3'b010;
   localparam logic [2:0] PPROT_INSTR  = 3'b100;

   localparam int unsigned RSP_DATA_W = 32;

   typedef struct packed {
      logic [RSP_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apb4_mst_rsp_t;

endpackage

// File: rtl/apb4_req_master.sv
// APB4 master: one SETUP/ACCESS transfer per accepted command, result on a
// valid/ready response port, with a saturating watchdog on stalled PREADY.
module apb4_req_master
   import apb4_req_master_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_write_i,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [DATA_WIDTH-1:0]   req_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] req_strb_i,
   input  logic [2:0]              req_prot_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic                    rsp_timeout_o,
   output logic [ADDR_WIDTH-1:0]   paddr_o,
   output logic [2:0]              pprot_o,
   output logic                    psel_o,
   output logic                    penable_o,
   output logic                    pwrite_o,
   output logic [DATA_WIDTH-1:0]   pwdata_o,
   output logic [DATA_WIDTH/8-1:0] pstrb_o,
   input  logic                    pready_i,
   input  logic [DATA_WIDTH-1:0]   prdata_i,
   input  logic                    pslverr_i
);

   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   // Abort fires during the TIMEOUT-th low-PREADY cycle, i.e. when TIMEOUT-1 cycles were already counted.
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   apb4_mst_state_e r_state, w_state_nxt;
   apb4_mst_rsp_t   r_rsp, w_rsp_nxt;

   logic [CNT_W-1:0]        r_wdog;
   logic [ADDR_WIDTH-1:0]   r_paddr;
   logic [2:0]              r_pprot;
   logic                    r_pwrite;
   logic [DATA_WIDTH-1:0]   r_pwdata;
   logic [DATA_WIDTH/8-1:0] r_pstrb;

   logic w_accept;
   logic w_expire;

   assign w_expire = (TIMEOUT != 0) && (r_wdog == CNT_LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rsp_nxt   = r_rsp;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid_i) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            w_state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            // A completing PREADY takes priority over a watchdog expiring in the same cycle.
            if (pready_i) begin
               w_state_nxt       = ST_RESP;
               w_rsp_nxt.rdata   = '0;
               if (!r_pwrite) begin
                  w_rsp_nxt.rdata[DATA_WIDTH-1:0] = prdata_i;
               end
               w_rsp_nxt.err     = pslverr_i;
               w_rsp_nxt.timeout = 1'b0;
            end else if (w_expire) begin
               w_state_nxt       = ST_RESP;
               w_rsp_nxt.rdata   = '0;
               w_rsp_nxt.err     = 1'b1;
               w_rsp_nxt.timeout = 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_paddr  <= '0;
         r_pprot  <= '0;
         r_pwrite <= 1'b0;
         r_pwdata <= '0;
         r_pstrb  <= '0;
         r_wdog   <= '0;
         r_rsp    <= '0;
      end else begin
         r_rsp <= w_rsp_nxt;
         if (w_accept) begin
            r_paddr  <= req_addr_i;
            r_pprot  <= req_prot_i;
            r_pwrite <= req_write_i;
            r_pwdata <= req_wdata_i;
            r_pstrb  <= req_write_i ? req_strb_i : '0;
            r_wdog   <= '0;
         end else if ((r_state == ST_ACCESS) && !pready_i && (r_wdog != '1)) begin
            r_wdog <= r_wdog + 1'b1;
         end
      end
   end

   assign req_ready_o   = (r_state == ST_IDLE);
   assign psel_o        = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
   assign penable_o     = (r_state == ST_ACCESS);
   assign rsp_valid_o   = (r_state == ST_RESP);
   assign rsp_rdata_o   = r_rsp.rdata[DATA_WIDTH-1:0];
   assign rsp_err_o     = r_rsp.err;
   assign rsp_timeout_o = r_rsp.timeout;
   assign paddr_o       = r_paddr;
   assign pprot_o       = r_pprot;
   assign pwrite_o      = r_pwrite;
   assign pwdata_o      = r_pwdata;
   assign pstrb_o       = r_pstrb;

endmodule

// File: tb/tb_apb4_req_master.sv
// Directed bench for apb4_req_master, instantiated with a short watchdog.
module tb_apb4_req_master;
   import apb4_req_master_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_write = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_strb = '0;
   logic [2:0]  req_prot = '0;
   logic        rsp_ready = 1'b0;
   logic        pready = 1'b1, pslverr = 1'b0;
   logic [31:0] prdata = '0;
   logic        req_ready, rsp_valid, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata, paddr, pwdata;
   logic [2:0]  pprot;
   logic        psel, penable, pwrite;
   logic [3:0]  pstrb;

   int checks = 0;
   int errors = 0;

   apb4_req_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
      .req_prot_i(req_prot),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
      .paddr_o(paddr), .pprot_o(pprot), .psel_o(psel), .penable_o(penable),
      .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
      .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Presents one command for a single edge, leaving the FSM in SETUP.
   task automatic accept_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [2:0] p);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_strb = s; req_prot = p;
      tick;
      req_valid = 1'b0;
   endtask

   task automatic finish_rsp;
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      checks++; if (psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL rst_psel_penable got %b%b exp 00", psel, penable); end
      checks++; if (paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0 || pprot !== 3'h0 || pwrite !== 1'b0) begin
         errors++; $display("FAIL rst_apb_regs got %h %h %h %h %b exp zeros", paddr, pwdata, pstrb, pprot, pwrite); end
      checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL rst_rsp got %b %b %b %h exp zeros", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
      tick; tick;
      rst = 1'b0;
      tick;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
   endtask

   task automatic test_write;
      pready = 1'b1; rsp_ready = 1'b0;
      accept_cmd(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, PPROT_NONSEC);
      checks++; if (psel !== 1'b1 || penable !== 1'b0) begin errors++; $display("FAIL wr_setup got psel=%b pen=%b exp 1 0", psel, penable); end
      checks++; if (paddr !== 32'h1000 || pwdata !== 32'hDEADBEEF || pstrb !== 4'hF || pwrite !== 1'b1 || pprot !== 3'b010) begin
         errors++; $display("FAIL wr_setup_bus got %h %h %h %b %h", paddr, pwdata, pstrb, pwrite, pprot); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wr_req_ready_busy got %b exp 0", req_ready); end
      tick;
      checks++; if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 32'h1000) begin
         errors++; $display("FAIL wr_access got psel=%b pen=%b addr=%h exp 1 1 1000", psel, penable, paddr); end
      tick;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL wr_rsp got v=%b e=%b t=%b d=%h exp 1 0 0 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
      checks++; if (psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL wr_resp_psel got %b%b exp 00", psel, penable); end
      finish_rsp;
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL wr_done got v=%b rdy=%b exp 0 1", rsp_valid, req_ready); end
   endtask

   task automatic test_read_wait;
      int lat = 0;
      int addr_bad = 0;
      pready = 1'b0; prdata = 32'h0;
      accept_cmd(1'b0, 32'h0004, 32'h0, 4'hF, 3'b000);
      checks++; if (pstrb !== 4'h0 || pwrite !== 1'b0) begin errors++; $display("FAIL rd_pstrb got %h wr=%b exp 0 0", pstrb, pwrite); end
      for (int k = 1; k <= 20; k++) begin
         if (k == 5) begin pready = 1'b1; prdata = 32'h12345678; end
         tick;
         if (psel && paddr !== 32'h0004) addr_bad++;
         if (rsp_valid) begin lat = k; break; end
      end
      checks++; if (lat != 5) begin errors++; $display("FAIL rd_wait_latency got %0d exp 5", lat); end
      checks++; if (addr_bad != 0) begin errors++; $display("FAIL rd_addr_stable got %0d bad cycles exp 0", addr_bad); end
      checks++; if (rsp_rdata !== 32'h12345678 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
         errors++; $display("FAIL rd_wait_rsp got d=%h e=%b t=%b exp 12345678 0 0", rsp_rdata, rsp_err, rsp_timeout); end
      finish_rsp;
      pready = 1'b1;
   endtask

   task automatic test_slverr;
      pready = 1'b1; pslverr = 1'b1; prdata = 32'hA5A5A5A5;
      accept_cmd(1'b0, 32'h0008, 32'h0, 4'h0, PPROT_PRIV);
      tick; tick;
      pslverr = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'hA5A5A5A5) begin
         errors++; $display("FAIL slverr_rsp got v=%b e=%b t=%b d=%h exp 1 1 0 a5a5a5a5", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
      finish_rsp;
   endtask

   task automatic test_timeout;
      int early = 0;
      pready = 1'b0; prdata = 32'hFFFFFFFF;
      accept_cmd(1'b0, 32'h0020, 32'h0, 4'h0, 3'b000);
      for (int k = 1; k <= 4; k++) begin
         tick;
         if (rsp_valid || !psel || !penable) early++;
      end
      checks++; if (early != 0) begin errors++; $display("FAIL to_early got %0d bad cycles exp 0", early); end
      tick;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL to_rsp got v=%b e=%b t=%b d=%h exp 1 1 1 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
      checks++; if (psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL to_psel got %b%b exp 00", psel, penable); end
      finish_rsp;
      pready = 1'b1;
   endtask

   task automatic test_pready_wins;
      pready = 1'b0; prdata = 32'h0;
      accept_cmd(1'b0, 32'h0024, 32'h0, 4'h0, 3'b000);
      tick; tick; tick; tick;
      pready = 1'b1; prdata = 32'hCAFE0001;
      tick;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'hCAFE0001) begin
         errors++; $display("FAIL race_rsp got v=%b e=%b t=%b d=%h exp 1 0 0 cafe0001", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
      finish_rsp;
   endtask

   task automatic test_backpressure;
      int bad = 0;
      pready = 1'b1; rsp_ready = 1'b0;
      accept_cmd(1'b1, 32'h0040, 32'h11223344, 4'h5, 3'b000);
      tick; tick;
      for (int k = 0; k < 5; k++) begin
         if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || psel !== 1'b0) bad++;
         tick;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_still_valid got %b exp 1", rsp_valid); end
      finish_rsp;
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b rdy=%b exp 0 1", rsp_valid, req_ready); end
   endtask

   task automatic test_reset_mid;
      pready = 1'b0;
      accept_cmd(1'b1, 32'h0080, 32'h99999999, 4'hF, 3'b111);
      tick;
      #2 rst = 1'b1;
      #1;
      checks++; if (psel !== 1'b0 || penable !== 1'b0 || paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0 || pprot !== 3'h0 || pwrite !== 1'b0) begin
         errors++; $display("FAIL mid_rst_apb got sel=%b en=%b a=%h d=%h s=%h p=%h w=%b exp zeros", psel, penable, paddr, pwdata, pstrb, pprot, pwrite); end
      checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin
         errors++; $display("FAIL mid_rst_rsp got %b %b %b %h exp zeros", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
      tick;
      rst = 1'b0; pready = 1'b1;
      tick;
      accept_cmd(1'b1, 32'h0084, 32'h55AA55AA, 4'h3, 3'b000);
      checks++; if (psel !== 1'b1 || paddr !== 32'h0084 || pwdata !== 32'h55AA55AA || pstrb !== 4'h3) begin
         errors++; $display("FAIL post_rst_setup got sel=%b a=%h d=%h s=%h", psel, paddr, pwdata, pstrb); end
      tick; tick;
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
         errors++; $display("FAIL post_rst_rsp got v=%b e=%b t=%b exp 1 0 0", rsp_valid, rsp_err, rsp_timeout); end
      finish_rsp;
   endtask

   task automatic test_back_to_back;
      logic [6:0] seen;
      pready = 1'b1; rsp_ready = 1'b1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got %b exp 1", req_ready); end
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0100; req_wdata = 32'h1; req_strb = 4'hF; req_prot = 3'b000;
      tick;
      for (int k = 1; k <= 7; k++) begin
         tick;
         seen[k-1] = req_ready;
      end
      req_valid = 1'b0; rsp_ready = 1'b0;
      checks++; if (seen !== 7'b1000100) begin errors++; $display("FAIL b2b_ready_pattern got %b exp 1000100", seen); end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_write;
      test_read_wait;
      test_slverr;
      test_timeout;
      test_pready_wins;
      test_backpressure;
      test_reset_mid;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
